// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types and the arbitration helper for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

  // DM wins by default; IF wins a contested round once the DM streak is full.
  function automatic arb_owner_e arb_pick(input logic cand_if, input logic cand_dm,
                                          input logic streak_full);
    arb_owner_e pick;
    pick = OWN_NONE;
    if (cand_dm && !(cand_if && streak_full)) begin
      pick = OWN_DM;
    end else if (cand_if) begin
      pick = OWN_IF;
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
// ============================================================================
// Module   : mem_port_arbiter_watchdog
// Purpose  : Cycle counter that flags a transaction stuck longer than
//            TIMEOUT_CYCLES. Only built when MEM_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MEM_ARB_TIMEOUT_EN
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Count busy cycles; any state change starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || restart) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // count holds cycles already spent, so the limit is reached in the
  // TIMEOUT_CYCLES-th busy cycle.
  assign expired = active && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between fetch (IF) and data (DM)
//            requesters, one transaction outstanding at a time, with a DM
//            streak limit so IF cannot starve.
// Config   : MEM_ARB_TIMEOUT_EN - enables the transaction watchdog / err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DM_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    stall_if_o,
  output logic                    stall_mem_o,
  output logic                    err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  typedef struct packed {
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = '0;

  arb_state_e            state, state_next;
  arb_owner_e            owner, owner_next, winner;
  logic [STREAK_W-1:0]   streak, streak_next;
  logic                  req_valid, req_valid_next;
  mem_req_t              fields, fields_next;
  logic                  cand_if, cand_dm, arbitrate;
  logic                  timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_active, wd_restart;
  assign wd_active  = (state != IDLE);
  assign wd_restart = (state_next != state);

  mem_port_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (wd_active),
    .restart (wd_restart),
    .expired (timeout)
  );
`else
  // The limit only matters when the watchdog is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // Next state, response routing and arbitration of the next owner.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    streak_next    = streak;
    req_valid_next = req_valid;
    fields_next    = fields;
    cand_if        = 1'b0;
    cand_dm        = 1'b0;
    arbitrate      = 1'b0;
    winner         = OWN_NONE;
    if_gnt_o       = 1'b0;
    dm_gnt_o       = 1'b0;
    if_rvalid_o    = 1'b0;
    dm_rvalid_o    = 1'b0;
    if_rdata_o     = '0;
    dm_rdata_o     = '0;

    if (timeout) begin
      // Abort: owner sees a zero-data response and the memory request drops.
      if_rvalid_o    = (owner == OWN_IF);
      dm_rvalid_o    = (owner == OWN_DM);
      state_next     = IDLE;
      owner_next     = OWN_NONE;
      req_valid_next = 1'b0;
      fields_next    = MEM_REQ_IDLE;
    end else begin
      case (state)
        IDLE: begin
          cand_if   = if_req_i;
          cand_dm   = dm_req_i;
          arbitrate = 1'b1;
        end
        REQ: begin
          if (mem_gnt_i) begin
            if_gnt_o       = (owner == OWN_IF);
            dm_gnt_o       = (owner == OWN_DM);
            state_next     = WAIT_RSP;
            req_valid_next = 1'b0;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            if (owner == OWN_IF) begin
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i;
            end
            if (owner == OWN_DM) begin
              dm_rvalid_o = 1'b1;
              dm_rdata_o  = mem_rdata_i;
            end
            // The completing side's req belongs to its next access, not this round.
            cand_if        = if_req_i && (owner != OWN_IF);
            cand_dm        = dm_req_i && (owner != OWN_DM);
            arbitrate      = 1'b1;
            state_next     = IDLE;
            owner_next     = OWN_NONE;
            req_valid_next = 1'b0;
            fields_next    = MEM_REQ_IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (arbitrate) begin
      winner = arb_pick(cand_if, cand_dm, streak == STREAK_MAX);
      if (winner != OWN_NONE) begin
        state_next     = REQ;
        owner_next     = winner;
        req_valid_next = 1'b1;
        if (winner == OWN_DM) begin
          fields_next.we    = dm_we_i;
          fields_next.be    = dm_be_i;
          fields_next.addr  = dm_addr_i;
          fields_next.wdata = dm_wdata_i;
          if (if_req_i && (streak != STREAK_MAX)) begin
            streak_next = streak + 1'b1;
          end
        end else begin
          fields_next      = MEM_REQ_IDLE;
          fields_next.be   = '1;
          fields_next.addr = if_addr_i;
          streak_next      = '0;
        end
      end
    end
  end

  // State, owner, streak and registered memory-side request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      streak    <= '0;
      req_valid <= 1'b0;
      fields    <= MEM_REQ_IDLE;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      streak    <= streak_next;
      req_valid <= req_valid_next;
      fields    <= fields_next;
    end
  end

  assign mem_req_o   = req_valid;
  assign mem_we_o    = fields.we;
  assign mem_be_o    = fields.be;
  assign mem_addr_o  = fields.addr;
  assign mem_wdata_o = fields.wdata;
  assign stall_if_o  = if_req_i & ~if_rvalid_o;
  assign stall_mem_o = dm_req_i & ~dm_rvalid_o;
  assign err_o       = timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (vector table plus
//            directed multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_if_o, stall_mem_o, err_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DM_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
    logic        g;   logic rv; logic [31:0] rd;
    logic        em;  logic [31:0] ema; logic ewe; logic [3:0] ebe; logic [31:0] ewd;
    logic        eig; logic eirv; logic [31:0] eird;
    logic        edg; logic edrv; logic [31:0] edrd;
    logic        esi; logic esd;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [3:0] dbe, input logic [31:0] da,
    input logic [31:0] dwd, input logic g, input logic rv, input logic [31:0] rd,
    input logic em, input logic [31:0] ema, input logic ewe, input logic [3:0] ebe,
    input logic [31:0] ewd, input logic eig, input logic eirv, input logic [31:0] eird,
    input logic edg, input logic edrv, input logic [31:0] edrd,
    input logic esi, input logic esd);
    vec_t v;
    v.nm = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da;
    v.dwd = dwd; v.g = g; v.rv = rv; v.rd = rd; v.em = em; v.ema = ema; v.ewe = ewe;
    v.ebe = ebe; v.ewd = ewd; v.eig = eig; v.eirv = eirv; v.eird = eird; v.edg = edg;
    v.edrv = edrv; v.edrd = edrd; v.esi = esi; v.esd = esd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req_i = N; if_addr_i = '0;
    dm_req_i = N; dm_we_i = N; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_gnt_i = N; mem_rvalid_i = N; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n = N;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = Y;
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic exp_if_win [6];
    logic got_if_win [6];
    int   ngr;

    // --- reset state --------------------------------------------------------
    rst_n = N;
    clear_inputs();
    @(negedge clk); #1;
    check("rst.mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst.mem_addr", mem_addr_o, 32'd0);
    check("rst.rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
    check("rst.gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd0);
    check("rst.err", {31'd0, err_o}, 32'd0);
    if_req_i = Y; #1;
    check("rst.stall_if_follows_req", {31'd0, stall_if_o}, 32'd1);
    if_req_i = N;
    @(negedge clk);
    rst_n = Y;

    // --- vector table: IF read, DM write, DM read with stray rvalid ---------
    //            name     ir ia          dr dw dbe   da          dwd          g  rv rd
    //                     em ema         ewe ebe   ewd          eig eirv eird  edg edrv edrd  esi esd
    vecs.push_back(mk("if.c0", Y, 32'h100, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, Y, N));
    vecs.push_back(mk("if.c1", Y, 32'h100, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0,
                      Y, 32'h100, N, 4'hf, 32'h0, N, N, 32'h0, N, N, 32'h0, Y, N));
    vecs.push_back(mk("if.c2", Y, 32'h100, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0,
                      Y, 32'h100, N, 4'hf, 32'h0, Y, N, 32'h0, N, N, 32'h0, Y, N));
    vecs.push_back(mk("if.c3", Y, 32'h100, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, Y, N));
    vecs.push_back(mk("if.c4", Y, 32'h100, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'h00500093,
                      N, 32'h0, N, 4'h0, 32'h0, N, Y, 32'h00500093, N, N, 32'h0, N, N));
    vecs.push_back(mk("if.c5", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, N, N));
    vecs.push_back(mk("wr.c0", N, 32'h0, Y, Y, 4'h3, 32'h2000, 32'hDEADBEEF, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, N, Y));
    vecs.push_back(mk("wr.c1", N, 32'h0, Y, Y, 4'h3, 32'h2000, 32'hDEADBEEF, N, N, 32'h0,
                      Y, 32'h2000, Y, 4'h3, 32'hDEADBEEF, N, N, 32'h0, N, N, 32'h0, N, Y));
    vecs.push_back(mk("wr.c2", N, 32'h0, Y, Y, 4'h3, 32'h2000, 32'hDEADBEEF, Y, N, 32'h0,
                      Y, 32'h2000, Y, 4'h3, 32'hDEADBEEF, N, N, 32'h0, Y, N, 32'h0, N, Y));
    vecs.push_back(mk("wr.c3", N, 32'h0, Y, Y, 4'h3, 32'h2000, 32'hDEADBEEF, N, Y, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, Y, 32'h0, N, N));
    vecs.push_back(mk("wr.c4", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, N, N));
    vecs.push_back(mk("rd.c0", N, 32'h0, Y, N, 4'hf, 32'h3000, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, N, Y));
    vecs.push_back(mk("rd.c1_stray_rvalid", N, 32'h0, Y, N, 4'hf, 32'h3000, 32'h0, N, Y, 32'h11111111,
                      Y, 32'h3000, N, 4'hf, 32'h0, N, N, 32'h0, N, N, 32'h0, N, Y));
    vecs.push_back(mk("rd.c2", N, 32'h0, Y, N, 4'hf, 32'h3000, 32'h0, Y, N, 32'h0,
                      Y, 32'h3000, N, 4'hf, 32'h0, N, N, 32'h0, Y, N, 32'h0, N, Y));
    vecs.push_back(mk("rd.c3", N, 32'h0, Y, N, 4'hf, 32'h3000, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, N, Y));
    vecs.push_back(mk("rd.c4", N, 32'h0, Y, N, 4'hf, 32'h3000, 32'h0, N, Y, 32'hCAFEF00D,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, Y, 32'hCAFEF00D, N, N));
    vecs.push_back(mk("rd.c5", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0,
                      N, 32'h0, N, 4'h0, 32'h0, N, N, 32'h0, N, N, 32'h0, N, N));

    foreach (vecs[k]) begin
      @(negedge clk);
      if_req_i = vecs[k].ir; if_addr_i = vecs[k].ia;
      dm_req_i = vecs[k].dr; dm_we_i = vecs[k].dw; dm_be_i = vecs[k].dbe;
      dm_addr_i = vecs[k].da; dm_wdata_i = vecs[k].dwd;
      mem_gnt_i = vecs[k].g; mem_rvalid_i = vecs[k].rv; mem_rdata_i = vecs[k].rd;
      #1;
      check({vecs[k].nm, ".mem_req"}, {31'd0, mem_req_o}, {31'd0, vecs[k].em});
      if (vecs[k].em) begin
        check({vecs[k].nm, ".mem_addr"}, mem_addr_o, vecs[k].ema);
        check({vecs[k].nm, ".mem_we"}, {31'd0, mem_we_o}, {31'd0, vecs[k].ewe});
        check({vecs[k].nm, ".mem_be"}, {28'd0, mem_be_o}, {28'd0, vecs[k].ebe});
        check({vecs[k].nm, ".mem_wdata"}, mem_wdata_o, vecs[k].ewd);
      end
      check({vecs[k].nm, ".if_gnt"}, {31'd0, if_gnt_o}, {31'd0, vecs[k].eig});
      check({vecs[k].nm, ".if_rvalid"}, {31'd0, if_rvalid_o}, {31'd0, vecs[k].eirv});
      check({vecs[k].nm, ".if_rdata"}, if_rdata_o, vecs[k].eird);
      check({vecs[k].nm, ".dm_gnt"}, {31'd0, dm_gnt_o}, {31'd0, vecs[k].edg});
      check({vecs[k].nm, ".dm_rvalid"}, {31'd0, dm_rvalid_o}, {31'd0, vecs[k].edrv});
      check({vecs[k].nm, ".dm_rdata"}, dm_rdata_o, vecs[k].edrd);
      check({vecs[k].nm, ".stall_if"}, {31'd0, stall_if_o}, {31'd0, vecs[k].esi});
      check({vecs[k].nm, ".stall_mem"}, {31'd0, stall_mem_o}, {31'd0, vecs[k].esd});
      check({vecs[k].nm, ".err"}, {31'd0, err_o}, 32'd0);
    end

    // --- held contention: completing side is not pending, so owners alternate
    do_reset();
    exp_if_win = '{N, Y, N, Y, N, Y};
    ngr = 0;
    for (int c = 0; c < 20 && ngr < 6; c++) begin
      @(negedge clk);
      if_req_i = Y; if_addr_i = 32'h100;
      dm_req_i = Y; dm_addr_i = 32'h3000; dm_be_i = 4'hf;
      mem_gnt_i = Y; mem_rvalid_i = Y; mem_rdata_i = 32'(c);
      #1;
      if (if_gnt_o && dm_gnt_o) check("contend.double_gnt", 32'd1, 32'd0);
      if (if_gnt_o || dm_gnt_o) begin
        got_if_win[ngr] = if_gnt_o;
        ngr++;
      end
    end
    check("contend.grant_count", ngr, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ngr) check($sformatf("contend.grant%0d_is_if", i), {31'd0, got_if_win[i]},
                         {31'd0, exp_if_win[i]});
    end

    // --- streak: loser withdraws each round; 5th contested round goes to IF
    do_reset();
    exp_if_win = '{N, N, N, N, Y, N};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      if_req_i = Y; if_addr_i = 32'h100;
      dm_req_i = Y; dm_addr_i = 32'h3000; dm_be_i = 4'hf;
      #1;
      check($sformatf("streak%0d.idle_mem_req", i), {31'd0, mem_req_o}, 32'd0);
      @(negedge clk);
      if (exp_if_win[i]) dm_req_i = N; else if_req_i = N;
      mem_gnt_i = Y;
      #1;
      check($sformatf("streak%0d.mem_addr", i), mem_addr_o,
            exp_if_win[i] ? 32'h100 : 32'h3000);
      check($sformatf("streak%0d.if_gnt", i), {31'd0, if_gnt_o}, {31'd0, exp_if_win[i]});
      check($sformatf("streak%0d.dm_gnt", i), {31'd0, dm_gnt_o}, {31'd0, ~exp_if_win[i]});
      @(negedge clk);
      mem_gnt_i = N; mem_rvalid_i = Y; mem_rdata_i = 32'hA0 + 32'(i);
      #1;
      check($sformatf("streak%0d.rvalid", i), {30'd0, if_rvalid_o, dm_rvalid_o},
            exp_if_win[i] ? 32'd2 : 32'd1);
      @(negedge clk);
      clear_inputs();
      #1;
      check($sformatf("streak%0d.back_to_idle", i), {31'd0, mem_req_o}, 32'd0);
    end

    // --- back-to-back: IF pending during DM WAIT_RSP, no IDLE bubble ------
    do_reset();
    @(negedge clk);
    dm_req_i = Y; dm_addr_i = 32'h4000; dm_be_i = 4'hf; #1;
    @(negedge clk);
    mem_gnt_i = Y; #1;
    check("b2b.dm_gnt", {31'd0, dm_gnt_o}, 32'd1);
    @(negedge clk);
    mem_gnt_i = N; if_req_i = Y; if_addr_i = 32'h104; #1;
    check("b2b.wait_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("b2b.wait_stall_if", {31'd0, stall_if_o}, 32'd1);
    @(negedge clk);
    mem_rvalid_i = Y; mem_rdata_i = 32'h55; #1;
    check("b2b.dm_rvalid", {31'd0, dm_rvalid_o}, 32'd1);
    check("b2b.dm_rdata", dm_rdata_o, 32'h55);
    @(negedge clk);
    mem_rvalid_i = N; dm_req_i = N; #1;
    check("b2b.if_mem_req_next_cycle", {31'd0, mem_req_o}, 32'd1);
    check("b2b.if_mem_addr", mem_addr_o, 32'h104);
    @(negedge clk);
    mem_gnt_i = Y; #1;
    check("b2b.if_gnt", {31'd0, if_gnt_o}, 32'd1);
    @(negedge clk);
    mem_gnt_i = N; mem_rvalid_i = Y; mem_rdata_i = 32'h66; #1;
    check("b2b.if_rdata", if_rdata_o, 32'h66);

    // --- reset in WAIT_RSP, then a late mem_rvalid_i ------------------------
    do_reset();
    @(negedge clk);
    if_req_i = Y; if_addr_i = 32'h200; #1;
    @(negedge clk);
    mem_gnt_i = Y; #1;
    @(negedge clk);
    mem_gnt_i = N; #1;
    rst_n = N; if_req_i = N; #1;
    check("rstmid.mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rstmid.mem_addr", mem_addr_o, 32'd0);
    check("rstmid.stall_if", {31'd0, stall_if_o}, 32'd0);
    @(negedge clk);
    rst_n = Y;
    @(negedge clk);
    mem_rvalid_i = Y; mem_rdata_i = 32'h77; #1;
    check("rstmid.late_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
    check("rstmid.late_rdata", if_rdata_o | dm_rdata_o, 32'd0);
    @(negedge clk);
    mem_rvalid_i = N; dm_req_i = Y; dm_addr_i = 32'h5000; #1;
    check("rstmid.idle_no_req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk); #1;
    check("rstmid.new_req", {31'd0, mem_req_o}, 32'd1);
    check("rstmid.new_addr", mem_addr_o, 32'h5000);

    // --- memory never grants ------------------------------------------------
    do_reset();
    @(negedge clk);
    if_req_i = Y; if_addr_i = 32'h300; #1;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); #1;
      if (c <= 8) begin
        check($sformatf("wdog.c%0d.mem_req", c), {31'd0, mem_req_o}, 32'd1);
        check($sformatf("wdog.c%0d.err", c), {31'd0, err_o}, (c == 8) ? 32'd1 : 32'd0);
        check($sformatf("wdog.c%0d.if_rvalid", c), {31'd0, if_rvalid_o},
              (c == 8) ? 32'd1 : 32'd0);
        check($sformatf("wdog.c%0d.if_rdata", c), if_rdata_o, 32'd0);
      end else begin
        check("wdog.after.mem_req", {31'd0, mem_req_o}, 32'd0);
        check("wdog.after.err", {31'd0, err_o}, 32'd0);
      end
    end
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      check($sformatf("stuck.c%0d.mem_req", c), {31'd0, mem_req_o}, 32'd1);
      check($sformatf("stuck.c%0d.err_rvalid", c), {30'd0, err_o, if_rvalid_o}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
